// File: rtl/fetch_unit_if.sv
// Fetch bus bundle: memory read port plus decode handshake and redirect.
// master = fetch_unit side, slave = memory/decode/control side.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [1:0]            mem_access_size;
  logic                  mem_rw;
  logic                  mem_enable;
  logic                  mem_busy;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic [DATA_WIDTH-1:0] insn;
  logic [ADDR_WIDTH-1:0] insn_pc;
  logic                  insn_valid;
  logic                  insn_ready;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    output mem_address, mem_access_size,
    output mem_rw, mem_enable,
    input  mem_busy, mem_data_out,
    output insn, insn_pc, insn_valid,
    input  insn_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_address, mem_access_size,
    input  mem_rw, mem_enable,
    output mem_busy, mem_data_out,
    input  insn, insn_pc, insn_valid,
    output insn_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-word memory reads, in-order queue to decode.
// Ports: clock, reset_n (async low), bus (fetch_unit_if.master).
module fetch_unit #(
  parameter int               ADDR_WIDTH = 32,
  parameter int               DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8002_0000,
  parameter int               DEPTH      = 4
) (
  input logic          clock,
  input logic          reset_n,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  discard_q, discard_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

  logic [CW:0] occ;
  logic        accept;
  logic        push;
  logic        pop;

  // Occupancy counts the in-flight word so a response always has a slot.
  assign occ = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};

  assign bus.mem_enable      = reset_n && (occ < (CW+1)'(DEPTH));
  assign bus.mem_address     = pc_q;
  assign bus.mem_access_size = 2'b00;
  assign bus.mem_rw          = 1'b0;

  assign bus.insn_valid = (count_q != '0);
  assign bus.insn       = data_q[head_q];
  assign bus.insn_pc    = addr_q[head_q];

  assign accept = bus.mem_enable && !bus.mem_busy;
  assign push   = inflight_q && !discard_q && !bus.redirect;
  assign pop    = bus.insn_valid && bus.insn_ready && !bus.redirect;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = accept;
    inflight_pc_d = inflight_pc_q;
    discard_d     = 1'b0;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (accept) begin
      inflight_pc_d = pc_q;
      pc_d          = pc_q + ADDR_WIDTH'(4);
    end

    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);

    unique case (1'b1)
      bus.redirect: begin
        pc_d      = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        // A request accepted alongside the redirect belongs to the old path.
        discard_d = accept;
        head_d    = '0;
        tail_d    = '0;
        count_d   = '0;
      end
      push && !pop: count_d = count_q + CW'(1);
      pop && !push: count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      discard_q     <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      discard_q     <= discard_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (push) begin
      data_q[tail_q] <= bus.mem_data_out;
      addr_q[tail_q] <= inflight_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency memory model.
// Memory word at address A is ~A.
module tb_fetch_unit;
  localparam logic [31:0] RP = 32'h8002_0000;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock)
    if (bus.mem_enable && !bus.mem_busy)
      bus.mem_data_out <= ~bus.mem_address;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic do_reset();
    bus.insn_ready  = 1'b0;
    bus.mem_busy    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.insn_ready  = 1'b0;
    bus.mem_busy    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (bus.mem_address !== RP) begin
      bad++;
      $display("FAIL rst_addr got=%h exp=%h", bus.mem_address, RP);
    end
    total++;
    if (bus.mem_enable !== 1'b0) begin
      bad++;
      $display("FAIL rst_en got=%b exp=0", bus.mem_enable);
    end
    total++;
    if (bus.mem_access_size !== 2'b00 || bus.mem_rw !== 1'b0) begin
      bad++;
      $display("FAIL rst_size_rw got=%b/%b exp=00/0",
               bus.mem_access_size, bus.mem_rw);
    end
    total++;
    if (bus.insn_valid !== 1'b0 || bus.insn !== 32'h0 ||
        bus.insn_pc !== 32'h0) begin
      bad++;
      $display("FAIL rst_insn got=%b/%h/%h exp=0/0/0",
               bus.insn_valid, bus.insn, bus.insn_pc);
    end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    bus.insn_ready = 1'b1;
    @(negedge clock);
    total++;
    if (bus.insn_valid !== 1'b0 || bus.mem_address !== RP + 4) begin
      bad++;
      $display("FAIL stream_e1 got=%b/%h exp=0/%h",
               bus.insn_valid, bus.mem_address, RP + 4);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      e = RP + 32'(4 * k);
      total++;
      if (bus.insn_valid !== 1'b1 || bus.insn_pc !== e ||
          bus.insn !== ~e) begin
        bad++;
        $display("FAIL stream_%0d got=%b/%h/%h exp=1/%h/%h",
                 k, bus.insn_valid, bus.insn_pc, bus.insn, e, ~e);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    int n;
    do_reset();
    repeat (10) @(negedge clock);
    total++;
    if (bus.insn_valid !== 1'b1 || bus.insn_pc !== RP ||
        bus.mem_enable !== 1'b0 || bus.mem_address !== RP + 16) begin
      bad++;
      $display("FAIL stall_full got=%b/%h/%b/%h exp=1/%h/0/%h",
               bus.insn_valid, bus.insn_pc, bus.mem_enable,
               bus.mem_address, RP, RP + 16);
    end
    bus.insn_ready = 1'b1;
    e = RP;
    n = 0;
    for (int c = 0; c < 20 && n < 8; c++) begin
      if (bus.insn_valid === 1'b1) begin
        total++;
        if (bus.insn_pc !== e || bus.insn !== ~e) begin
          bad++;
          $display("FAIL stall_seq got=%h/%h exp=%h/%h",
                   bus.insn_pc, bus.insn, e, ~e);
        end
        e = e + 4;
        n++;
      end
      @(negedge clock);
    end
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL stall_count got=%0d exp=8", n);
    end
  endtask

  task automatic test_busy();
    logic [31:0] e;
    int n;
    do_reset();
    bus.insn_ready = 1'b1;
    e = RP;
    n = 0;
    for (int c = 1; c < 30 && n < 6; c++) begin
      @(negedge clock);
      if (bus.insn_valid === 1'b1) begin
        total++;
        if (bus.insn_pc !== e || bus.insn !== ~e) begin
          bad++;
          $display("FAIL busy_seq got=%h/%h exp=%h/%h",
                   bus.insn_pc, bus.insn, e, ~e);
        end
        e = e + 4;
        n++;
      end
      bus.mem_busy = (c >= 2 && c <= 4);
      if (bus.mem_busy) begin
        #1;
        total++;
        if (bus.mem_address !== RP + 8 || bus.mem_enable !== 1'b1) begin
          bad++;
          $display("FAIL busy_hold got=%h/%b exp=%h/1",
                   bus.mem_address, bus.mem_enable, RP + 8);
        end
      end
    end
    bus.mem_busy = 1'b0;
    total++;
    if (n != 6) begin
      bad++;
      $display("FAIL busy_count got=%0d exp=6", n);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (4) @(negedge clock);
    total++;
    if (bus.insn_pc !== RP || bus.mem_enable !== 1'b0) begin
      bad++;
      $display("FAIL redir_pre got=%h/%b exp=%h/0",
               bus.insn_pc, bus.mem_enable, RP);
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = RP + 32'h103;
    @(negedge clock);
    bus.redirect = 1'b0;
    total++;
    if (bus.insn_valid !== 1'b0 || bus.mem_address !== RP + 32'h100 ||
        bus.mem_enable !== 1'b1) begin
      bad++;
      $display("FAIL redir_r got=%b/%h/%b exp=0/%h/1",
               bus.insn_valid, bus.mem_address, bus.mem_enable,
               RP + 32'h100);
    end
    bus.insn_ready = 1'b1;
    @(negedge clock);
    total++;
    if (bus.insn_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_r1 got=%b exp=0", bus.insn_valid);
    end
    @(negedge clock);
    total++;
    if (bus.insn_valid !== 1'b1 || bus.insn_pc !== RP + 32'h100 ||
        bus.insn !== ~(RP + 32'h100)) begin
      bad++;
      $display("FAIL redir_r2 got=%b/%h/%h exp=1/%h",
               bus.insn_valid, bus.insn_pc, bus.insn, RP + 32'h100);
    end
    @(negedge clock);
    total++;
    if (bus.insn_pc !== RP + 32'h104) begin
      bad++;
      $display("FAIL redir_r3 got=%h exp=%h",
               bus.insn_pc, RP + 32'h104);
    end
  endtask

  task automatic test_redirect_pop_push();
    do_reset();
    bus.insn_ready = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if (bus.insn_valid !== 1'b1 || bus.insn_pc !== RP + 4) begin
      bad++;
      $display("FAIL rpp_head got=%b/%h exp=1/%h",
               bus.insn_valid, bus.insn_pc, RP + 4);
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h9000_0000;
    @(negedge clock);
    bus.redirect = 1'b0;
    total++;
    if (bus.insn_valid !== 1'b0) begin
      bad++;
      $display("FAIL rpp_flush got=%b/%h exp=0",
               bus.insn_valid, bus.insn_pc);
    end
    @(negedge clock);
    total++;
    if (bus.insn_valid !== 1'b0) begin
      bad++;
      $display("FAIL rpp_discard got=%b/%h exp=0",
               bus.insn_valid, bus.insn_pc);
    end
    @(negedge clock);
    total++;
    if (bus.insn_valid !== 1'b1 || bus.insn_pc !== 32'h9000_0000) begin
      bad++;
      $display("FAIL rpp_new got=%b/%h exp=1/90000000",
               bus.insn_valid, bus.insn_pc);
    end
  endtask

  task automatic test_back_to_back();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h9000_0040;
    @(negedge clock);
    bus.redirect_pc = 32'h9000_0080;
    total++;
    if (bus.insn_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_r1 got=%b exp=0", bus.insn_valid);
    end
    @(negedge clock);
    bus.redirect = 1'b0;
    total++;
    if (bus.insn_valid !== 1'b0 || bus.mem_address !== 32'h9000_0080) begin
      bad++;
      $display("FAIL b2b_r2 got=%b/%h exp=0/90000080",
               bus.insn_valid, bus.mem_address);
    end
    @(negedge clock);
    total++;
    if (bus.insn_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drop got=%b/%h exp=0",
               bus.insn_valid, bus.insn_pc);
    end
    @(negedge clock);
    total++;
    if (bus.insn_valid !== 1'b1 || bus.insn_pc !== 32'h9000_0080) begin
      bad++;
      $display("FAIL b2b_last got=%b/%h exp=1/90000080",
               bus.insn_valid, bus.insn_pc);
    end
  endtask

  task automatic test_reset_mid_and_wrap();
    logic [31:0] w [3];
    w[0] = 32'hFFFF_FFF8;
    w[1] = 32'hFFFF_FFFC;
    w[2] = 32'h0000_0000;
    do_reset();
    bus.insn_ready = 1'b1;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (bus.insn_valid !== 1'b0 || bus.insn !== 32'h0 ||
        bus.insn_pc !== 32'h0 || bus.mem_enable !== 1'b0 ||
        bus.mem_address !== RP) begin
      bad++;
      $display("FAIL mid_rst got=%b/%h/%h/%b/%h exp=0/0/0/0/%h",
               bus.insn_valid, bus.insn, bus.insn_pc,
               bus.mem_enable, bus.mem_address, RP);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if (bus.insn_valid !== 1'b1 || bus.insn_pc !== RP) begin
      bad++;
      $display("FAIL mid_restart got=%b/%h exp=1/%h",
               bus.insn_valid, bus.insn_pc, RP);
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    @(negedge clock);
    bus.redirect = 1'b0;
    total++;
    if (bus.mem_address !== 32'hFFFF_FFF8) begin
      bad++;
      $display("FAIL wrap_pc got=%h exp=fffffff8", bus.mem_address);
    end
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      total++;
      if (bus.insn_valid !== 1'b1 || bus.insn_pc !== w[k] ||
          bus.insn !== ~w[k]) begin
        bad++;
        $display("FAIL wrap_%0d got=%b/%h/%h exp=1/%h",
                 k, bus.insn_valid, bus.insn_pc, bus.insn, w[k]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_stall();
    test_busy();
    test_redirect();
    test_redirect_pop_push();
    test_back_to_back();
    test_reset_mid_and_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
